// File: rtl/md5_pkg.sv
// rtl/md5_pkg.sv - shared MD5 round constants, K table and ROM lookup helper
package md5_pkg;

  localparam int unsigned KT_W      = 7;
  localparam int unsigned KT_OFFSET = 4;

  localparam logic [31:0] MD5_K [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Addresses outside the 64-entry window read as zero.
  function automatic logic [31:0] kt_lookup(input logic [KT_W-1:0] t,
                                            input int unsigned offset);
    int unsigned idx;
    logic [31:0] result;
    idx    = 32'(t);
    result = '0;
    if (idx >= offset && idx < offset + 32'd64) begin
      result = MD5_K[6'(idx - offset)];
    end
    return result;
  endfunction

endpackage

// File: rtl/md5_kt_rom.sv
// rtl/md5_kt_rom.sv - K[t] constant ROM with enable-gated pipeline registers
// MD5_KT_OUTREG_EN defined: two stages (latency 2); undefined: one stage (latency 1).
module md5_kt_rom
  import md5_pkg::*;
#(
  parameter int unsigned KT_OFFSET = md5_pkg::KT_OFFSET
) (
  input  logic            CLK,
  input  logic            rst_n,
  input  logic [KT_W-1:0] kt_t,
  input  logic            kt_en,
  input  logic            kt_rst,
  output logic [31:0]     Kt
);

  logic [31:0] rom_d;
  logic [31:0] data_q;

  assign rom_d = kt_lookup(kt_t, KT_OFFSET);

`ifdef MD5_KT_OUTREG_EN
  logic [31:0] out_q;

  // kt_rst only touches the output stage; stage 1 keeps streaming.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      out_q  <= '0;
    end else begin
      if (kt_en) begin
        data_q <= rom_d;
      end
      if (kt_rst) begin
        out_q <= '0;
      end else if (kt_en) begin
        out_q <= data_q;
      end
    end
  end

  assign Kt = out_q;
`else
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (kt_rst) begin
      data_q <= '0;
    end else if (kt_en) begin
      data_q <= rom_d;
    end
  end

  assign Kt = data_q;
`endif

endmodule

// File: rtl/md5_round_support.sv
// rtl/md5_round_support.sv - K[t] ROM, registered 3-input adder and enable/clear register
module md5_round_support
  import md5_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned KT_OFFSET = md5_pkg::KT_OFFSET
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic [KT_W-1:0]  kt_t,
  input  logic             kt_en,
  input  logic             kt_rst,
  output logic [31:0]      Kt,
  input  logic [WIDTH-1:0] add_a,
  input  logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_c,
  input  logic             add_en,
  input  logic             add_rst,
  output logic [WIDTH-1:0] add_o,
  input  logic [WIDTH-1:0] ff_i,
  input  logic             ff_en,
  input  logic             ff_rst,
  output logic [WIDTH-1:0] ff_o
);

  logic [WIDTH-1:0] add_d, add_q;
  logic [WIDTH-1:0] ff_d, ff_q;

  md5_kt_rom #(
    .KT_OFFSET(KT_OFFSET)
  ) u_kt_rom (
    .CLK   (CLK),
    .rst_n (rst_n),
    .kt_t  (kt_t),
    .kt_en (kt_en),
    .kt_rst(kt_rst),
    .Kt    (Kt)
  );

  // Sum wraps at WIDTH bits; carry-out is intentionally dropped.
  always_comb begin
    add_d = add_q;
    if (add_rst) begin
      add_d = '0;
    end else if (add_en) begin
      add_d = add_a + add_b + add_c;
    end
  end

  always_comb begin
    ff_d = ff_q;
    if (ff_rst) begin
      ff_d = '0;
    end else if (ff_en) begin
      ff_d = ff_i;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      add_q <= '0;
      ff_q  <= '0;
    end else begin
      add_q <= add_d;
      ff_q  <= ff_d;
    end
  end

  assign add_o = add_q;
  assign ff_o  = ff_q;

endmodule

// File: tb/tb_md5_round_support.sv
// tb/tb_md5_round_support.sv - directed self-checking bench for md5_round_support
module tb_md5_round_support;

`ifdef MD5_KT_OUTREG_EN
  localparam int KT_LAT = 2;
`else
  localparam int KT_LAT = 1;
`endif

  logic        CLK = 1'b0;
  logic        rst_n;
  logic [6:0]  kt_t;
  logic        kt_en, kt_rst;
  logic [31:0] Kt;
  logic [31:0] add_a, add_b, add_c;
  logic        add_en, add_rst;
  logic [31:0] add_o;
  logic [31:0] ff_i;
  logic        ff_en, ff_rst;
  logic [31:0] ff_o;

  int passed = 0;
  int total  = 0;

  md5_round_support #(.WIDTH(32), .KT_OFFSET(4)) dut (
    .CLK(CLK), .rst_n(rst_n),
    .kt_t(kt_t), .kt_en(kt_en), .kt_rst(kt_rst), .Kt(Kt),
    .add_a(add_a), .add_b(add_b), .add_c(add_c),
    .add_en(add_en), .add_rst(add_rst), .add_o(add_o),
    .ff_i(ff_i), .ff_en(ff_en), .ff_rst(ff_rst), .ff_o(ff_o)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    kt_t = '0; kt_en = 0; kt_rst = 0;
    add_a = '0; add_b = '0; add_c = '0; add_en = 0; add_rst = 0;
    ff_i = '0; ff_en = 0; ff_rst = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    for (int i = 0; i < 4; i++) begin
      kt_t = 7'($urandom_range(0, 127)); kt_en = 1'($urandom); kt_rst = 0;
      add_a = $urandom; add_b = $urandom; add_c = $urandom; add_en = 1; add_rst = 0;
      ff_i = $urandom; ff_en = 1; ff_rst = 0;
      step();
    end
    total++; if (Kt !== 32'h0) $display("FAIL reset_kt got %h want %h", Kt, 32'h0); else passed++;
    total++; if (add_o !== 32'h0) $display("FAIL reset_add got %h want %h", add_o, 32'h0); else passed++;
    total++; if (ff_o !== 32'h0) $display("FAIL reset_ff got %h want %h", ff_o, 32'h0); else passed++;
    idle_inputs();
    #2 rst_n = 1;
    kt_t = 7'd4; kt_en = 1;
    step();
    total++;
    if (Kt !== ((KT_LAT == 1) ? 32'hd76aa478 : 32'h0))
      $display("FAIL reset_first_edge got %h want %h", Kt, (KT_LAT == 1) ? 32'hd76aa478 : 32'h0);
    else passed++;
    for (int i = 1; i < KT_LAT; i++) step();
    total++; if (Kt !== 32'hd76aa478) $display("FAIL reset_k0_latency got %h want %h", Kt, 32'hd76aa478); else passed++;
  endtask

  task automatic test_rom_sweep();
    logic [31:0] exp;
    bit          chk;
    int          tt;
    idle_inputs();
    for (int j = 0; j < 128 + KT_LAT - 1; j++) begin
      kt_t  = (j < 128) ? 7'(j) : 7'd0;
      kt_en = 1;
      step();
      tt  = j - KT_LAT + 1;
      chk = 1;
      case (tt)
        4:  exp = 32'hd76aa478;
        5:  exp = 32'he8c7b756;
        19: exp = 32'h49b40821;
        20: exp = 32'hf61e2562;
        35: exp = 32'h8d2a4c8a;
        36: exp = 32'hfffa3942;
        52: exp = 32'hf4292244;
        67: exp = 32'heb86d391;
        default: begin
          exp = 32'h0;
          chk = (tt >= 0) && (tt < 4 || tt > 67);
        end
      endcase
      if (chk) begin
        total++;
        if (Kt !== exp) $display("FAIL rom_sweep t=%0d got %h want %h", tt, Kt, exp);
        else passed++;
      end
    end
  endtask

  task automatic test_rom_hold();
    idle_inputs();
    kt_t = 7'd4; kt_en = 1;
    for (int i = 0; i < KT_LAT; i++) step();
    total++; if (Kt !== 32'hd76aa478) $display("FAIL rom_hold_load got %h want %h", Kt, 32'hd76aa478); else passed++;
    kt_t = 7'd0; kt_en = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (Kt !== 32'hd76aa478) $display("FAIL rom_hold cycle=%0d got %h want %h", i, Kt, 32'hd76aa478);
      else passed++;
    end
  endtask

  task automatic test_rom_kt_rst();
    idle_inputs();
    kt_t = 7'd4; kt_en = 1;
    for (int i = 0; i < KT_LAT; i++) step();
    kt_t = 7'd5; kt_rst = 1;
    step();
    total++; if (Kt !== 32'h0) $display("FAIL kt_rst_clear got %h want %h", Kt, 32'h0); else passed++;
    kt_rst = 0;
    step();
    total++; if (Kt !== 32'he8c7b756) $display("FAIL kt_rst_resume got %h want %h", Kt, 32'he8c7b756); else passed++;
  endtask

  task automatic test_adder();
    idle_inputs();
    add_a = 32'hffffffff; add_b = 32'h1; add_c = 32'h1; add_en = 1;
    step();
    total++; if (add_o !== 32'h00000001) $display("FAIL add_wrap got %h want %h", add_o, 32'h1); else passed++;
    add_a = 32'h12345678; add_b = 32'h11111111; add_c = 32'h01010101; add_en = 0;
    step();
    total++; if (add_o !== 32'h00000001) $display("FAIL add_hold got %h want %h", add_o, 32'h1); else passed++;
    add_en = 1;
    step();
    total++; if (add_o !== 32'h2446688a) $display("FAIL add_sum got %h want %h", add_o, 32'h2446688a); else passed++;
    add_rst = 1;
    step();
    total++; if (add_o !== 32'h0) $display("FAIL add_rst got %h want %h", add_o, 32'h0); else passed++;
    add_rst = 0; add_en = 0;
  endtask

  task automatic test_ff();
    idle_inputs();
    ff_i = 32'h12345678; ff_en = 1;
    step();
    total++; if (ff_o !== 32'h12345678) $display("FAIL ff_load got %h want %h", ff_o, 32'h12345678); else passed++;
    ff_i = 32'h0; ff_en = 0;
    step();
    total++; if (ff_o !== 32'h12345678) $display("FAIL ff_hold got %h want %h", ff_o, 32'h12345678); else passed++;
    ff_rst = 1; ff_en = 1; ff_i = 32'hdeadbeef;
    step();
    total++; if (ff_o !== 32'h0) $display("FAIL ff_rst got %h want %h", ff_o, 32'h0); else passed++;
    ff_rst = 0; ff_en = 0;
  endtask

  task automatic test_concurrent_async_reset();
    idle_inputs();
    kt_t = 7'd20; kt_en = 1;
    add_a = 32'h1; add_b = 32'h2; add_c = 32'h3; add_en = 1;
    ff_i = 32'ha5a5a5a5; ff_en = 1;
    for (int i = 0; i < KT_LAT; i++) step();
    total++; if (Kt !== 32'hf61e2562) $display("FAIL conc_kt got %h want %h", Kt, 32'hf61e2562); else passed++;
    total++; if (add_o !== 32'h6) $display("FAIL conc_add got %h want %h", add_o, 32'h6); else passed++;
    total++; if (ff_o !== 32'ha5a5a5a5) $display("FAIL conc_ff got %h want %h", ff_o, 32'ha5a5a5a5); else passed++;
    kt_t = 7'd36;
    step();
    #1 rst_n = 0;
    #1;
    total++; if (Kt !== 32'h0) $display("FAIL async_kt got %h want %h", Kt, 32'h0); else passed++;
    total++; if (add_o !== 32'h0) $display("FAIL async_add got %h want %h", add_o, 32'h0); else passed++;
    total++; if (ff_o !== 32'h0) $display("FAIL async_ff got %h want %h", ff_o, 32'h0); else passed++;
    step();
    idle_inputs();
    #2 rst_n = 1;
    kt_t = 7'd4; kt_en = 1;
    step();
    total++;
    if (Kt !== ((KT_LAT == 1) ? 32'hd76aa478 : 32'h0))
      $display("FAIL post_reset_first got %h want %h", Kt, (KT_LAT == 1) ? 32'hd76aa478 : 32'h0);
    else passed++;
    for (int i = 1; i < KT_LAT; i++) step();
    total++; if (Kt !== 32'hd76aa478) $display("FAIL post_reset_k0 got %h want %h", Kt, 32'hd76aa478); else passed++;
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    test_reset();
    test_rom_sweep();
    test_rom_hold();
    test_rom_kt_rst();
    test_adder();
    test_ff();
    test_concurrent_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
